float_demux2: RTL and testbench
===============================

# float_demux2

Registered 1-to-2 demultiplexer for 32-bit single-precision operand words. It splits one valid/ready input stream into two output channels, each with its own small FIFO, so the float adder datapath can feed two downstream consumers independently. It is the distribution-side counterpart to the registered 2-to-1 operand select: words enter on one port and leave on the port named by `in_sel`. Word order is preserved within each channel.

## Interface
- `DEPTH`, default 2: entries per output FIFO. Must be a power of two, 2 or greater.
- `W`, default 32: data word width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `res`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word accepted this cycle when `in_valid` is also high.
- `in_data`  in  W  input word, IEEE-754 single-precision.
- `in_sel`  in  1  destination channel: 0 selects out0, 1 selects out1. Sampled with `in_data`.
- `out0_valid` / `out1_valid`  out  1  channel FIFO is non-empty.
- `out0_ready` / `out1_ready`  in  1  consumer pops the head word.
- `out0_data` / `out1_data`  out  W  channel FIFO head word.
- `drop_count`  out  8  count of NaN words discarded. Exists only with `FLOAT_DEMUX_NAN_DROP_EN`.

## Operation
- There is one FIFO per channel: FIFO0 and FIFO1. Each has a `DEPTH`-entry array, read and write pointers, and an occupancy count from 0 to `DEPTH`.
- `in_ready` = `!full[in_sel]`. It is purely combinational from `in_sel` and the registered full flags.
  - `in_ready` does not depend on the current-cycle `out*_ready`. A full FIFO never accepts a word, even if it is popped in the same cycle.
- Push: when `in_valid && in_ready`, write `in_data` to FIFO[`in_sel`] at its write pointer, then advance the pointer. The pointer wraps from `DEPTH-1` to 0.
- Pop: when `outN_valid && outN_ready`, advance the read pointer of FIFO N. The pointer wraps in the same way.
- Simultaneous push and pop on the same non-full, non-empty FIFO leaves the count unchanged and moves both pointers.
- Simultaneous push and pop on the same empty FIFO is impossible, because `valid` is low while the FIFO is empty. The push lands normally.
- Push to one channel and pop from the other in the same cycle are independent.
- `outN_data` = `mem[rd_ptr]`. It holds the last head value while the FIFO is empty; consumers ignore it when `valid` is low.
- `outN_ready` asserted while `outN_valid` is low has no effect.
- Reset (`res` high at a rising edge):
  - All pointers and counts go to 0, and both `outN_valid` go to 0.
  - `drop_count` goes to 0.
  - Memory contents are not cleared; `outN_data` reads the current `mem[0]`.
  - Reset in the middle of a stream discards all buffered words. An input handshake in the reset cycle is ignored.

## Timing
- Latency: a word accepted at edge k is visible on `outN_valid`/`outN_data` after edge k, i.e. in cycle k+1.
- Throughput: 1 word/cycle into a channel as long as its consumer holds `ready` high. With `DEPTH`=2 there are no bubbles.
- `in_ready` may change in the same cycle `in_sel` changes. The producer must hold `in_data`/`in_sel` stable while `in_valid` is high and `in_ready` is low.
- All outputs are registered state or muxes of registered state. There is no combinational path from `out*_ready` to any output.

## Configuration
- `FLOAT_DEMUX_NAN_DROP_EN` defined:
  - An input word is a NaN when exponent bits [30:23] are all 1 and mantissa bits [22:0] are non-zero.
  - For a NaN word, `in_ready` is forced to 1 regardless of FIFO state, and the word is not written.
  - `drop_count` increments by 1 per dropped word and saturates at 255.
  - Infinities (mantissa == 0) pass through normally.
- Undefined: every word is routed normally, NaN or not. The `drop_count` port and its counter are absent.

## Test plan
- Basic routing: reset, then push 0x3F800000 with sel=0 and 0x40000000 with sel=1, both ready high. Required: out0 shows 0x3F800000 one cycle after its push, out1 shows 0x40000000 one cycle after its push, each with valid high for 1 cycle.
- Full/backpressure: out0_ready=0, push 3 words with sel=0. Required: first 2 accepted, `in_ready`=0 on the 3rd. After `out0_ready` pulses once, the 3rd is accepted. Pop order matches push order: w0, w1, w2.
- Cross-channel independence: FIFO0 full. Push with sel=1. Required: `in_ready`=1, out1 receives the word, and FIFO0 contents are unchanged.
- Wrap-around: 10 push/pop pairs with sel=0 and a continuous stream 0x00000001..0x0000000A. Required: same sequence at out0, no drops, `out0_valid` continuous after the first cycle.
- Reset mid-stream: FIFO1 holding 2 words, assert `res` for 1 cycle. Required: `out1_valid`=0 the next cycle, and the held words never appear.
- NaN drop (macro on): push 0x7FC00000, then 0x7F800000. Required: first dropped with `drop_count`=1, second delivered; after 300 NaN pushes, `drop_count`=255.

Source files
------------

// File: rtl/float_demux2_if.sv
// Valid/ready bundle for the 1-to-2 operand demux:
// one input stream, two output channels.
interface float_demux2_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         in_sel;
  logic [W-1:0] in_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out0_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] out1_data;

  modport master (
    output in_valid, in_sel, in_data,
    output out0_ready, out1_ready,
    input  in_ready,
    input  out0_valid, out0_data,
    input  out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_sel, in_data,
    input  out0_ready, out1_ready,
    output in_ready,
    output out0_valid, out0_data,
    output out1_valid, out1_data
  );
endinterface

// File: rtl/float_demux2.sv
// Registered 1-to-2 float operand demux, one FIFO per channel.
// Define FLOAT_DEMUX_NAN_DROP_EN to discard NaN words and count them.
module float_demux2 #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic clk,
  input  logic res,
  float_demux2_if.slave bus
`ifdef FLOAT_DEMUX_NAN_DROP_EN
  ,
  output logic [7:0] drop_count
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [2][DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] wr_ptr_d [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [AW-1:0] rd_ptr_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_rdy;
  logic [1:0] sel_oh;
  logic       is_nan;
  logic       in_ready;

  always_comb begin
    out_rdy = {bus.out1_ready, bus.out0_ready};
    sel_oh  = {bus.in_sel, ~bus.in_sel};
`ifdef FLOAT_DEMUX_NAN_DROP_EN
    is_nan = (&bus.in_data[30:23]) &&
             (|bus.in_data[22:0]);
`else
    is_nan = 1'b0;
`endif
    for (int c = 0; c < 2; c++) begin
      full[c]  = (cnt_q[c] == FULL);
      valid[c] = (cnt_q[c] != '0);
    end
    // Full flag only: a same-cycle pop never frees a slot early.
    in_ready = is_nan | ~full[bus.in_sel];
    push = sel_oh &
           {2{bus.in_valid & in_ready & ~is_nan}};
    pop  = valid & out_rdy;
    for (int c = 0; c < 2; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + AW'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + AW'(pop[c]);
      cnt_d[c]    = cnt_q[c] + CW'(push[c])
                  - CW'(pop[c]);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (res) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end else begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  // Storage is never cleared; reset only drops the pointers.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!res && push[c])
        mem_q[c][wr_ptr_q[c]] <= bus.in_data;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = valid[0];
  assign bus.out1_valid = valid[1];
  assign bus.out0_data  = mem_q[0][rd_ptr_q[0]];
  assign bus.out1_data  = mem_q[1][rd_ptr_q[1]];

`ifdef FLOAT_DEMUX_NAN_DROP_EN
  logic [7:0] drop_q;
  logic [7:0] drop_d;

  always_comb begin
    drop_d = drop_q;
    if (bus.in_valid && is_nan && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (res) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif
endmodule

// File: tb/tb_float_demux2.sv
// Scoreboard bench for float_demux2: per-channel expected
// queues double as the occupancy model.
module tb_float_demux2;
  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  float_demux2_if #(.W(W)) bus ();
`ifdef FLOAT_DEMUX_NAN_DROP_EN
  logic [7:0] drop_count;
`endif

  float_demux2 #(
    .DEPTH(DEPTH),
    .W    (W)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
`ifdef FLOAT_DEMUX_NAN_DROP_EN
    ,
    .drop_count(drop_count)
`endif
  );

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  bit          en       = 1'b0;
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  int unsigned mdrop = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  function automatic bit nan_word(input logic [31:0] d);
`ifdef FLOAT_DEMUX_NAN_DROP_EN
    return (d[30:23] == 8'hFF) && (d[22:0] != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One cycle: drive at negedge, check in_ready at +1,
  // commit the model at +3 (monitor runs at +2).
  task automatic step(input logic v, input logic s,
                      input logic [31:0] d,
                      input logic r0, input logic r1,
                      input logic rs,
                      output logic acc);
    bit nan;
    bit rdy;
    @(negedge clk);
    res            = rs;
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #1;
    nan = nan_word(d);
    if (nan) rdy = 1'b1;
    else if (s) rdy = (q1.size() < DEPTH);
    else rdy = (q0.size() < DEPTH);
    check("in_ready", {31'b0, bus.in_ready},
          {31'b0, rdy});
    acc = v && rdy && !nan && !rs;
    #2;
    if (rs) begin
      q0.delete();
      q1.delete();
      mdrop = 0;
    end else if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end else if (v && nan && mdrop < 255) begin
      mdrop++;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (en) begin
        check("out0_valid", {31'b0, bus.out0_valid},
              {31'b0, q0.size() != 0});
        check("out1_valid", {31'b0, bus.out1_valid},
              {31'b0, q1.size() != 0});
        if (q0.size() != 0) begin
          check("out0_data", bus.out0_data, q0[0]);
          if (bus.out0_ready) void'(q0.pop_front());
        end
        if (q1.size() != 0) begin
          check("out1_data", bus.out1_data, q1[0]);
          if (bus.out1_ready) void'(q1.pop_front());
        end
`ifdef FLOAT_DEMUX_NAN_DROP_EN
        check("drop_count", {24'b0, drop_count},
              mdrop);
`endif
      end
    end
  end

  initial begin : driver
    logic a;
    logic v, s, r0, r1, rs;
    logic [31:0] d;
    res            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    en = 1'b1;
    step(0, 0, 0, 0, 0, 1, a);
    step(0, 0, 0, 0, 0, 0, a);

    // basic routing
    step(1, 0, 32'h3F800000, 1, 1, 0, a);
    step(1, 1, 32'h40000000, 1, 1, 0, a);
    step(0, 0, 0, 1, 1, 0, a);
    step(0, 0, 0, 1, 1, 0, a);

    // fill FIFO0, third word stalls until one pop
    step(1, 0, 32'h11111111, 0, 0, 0, a);
    step(1, 0, 32'h22222222, 0, 0, 0, a);
    step(1, 0, 32'h33333333, 0, 0, 0, a);
    step(1, 0, 32'h33333333, 1, 0, 0, a);
    step(1, 0, 32'h33333333, 0, 0, 0, a);
    // cross channel while FIFO0 full
    step(1, 1, 32'h44444444, 0, 0, 0, a);
    repeat (4) step(0, 0, 0, 1, 1, 0, a);

    // wrap-around stream
    for (int i = 1; i <= 10; i++)
      step(1, 0, i, 1, 0, 0, a);
    repeat (2) step(0, 0, 0, 1, 0, 0, a);

    // reset with FIFO1 holding two words
    step(1, 1, 32'hAAAA0001, 0, 0, 0, a);
    step(1, 1, 32'hAAAA0002, 0, 0, 0, a);
    step(1, 1, 32'hAAAA0003, 0, 1, 1, a);
    repeat (3) step(0, 0, 0, 1, 1, 0, a);

`ifdef FLOAT_DEMUX_NAN_DROP_EN
    step(1, 0, 32'h7FC00000, 1, 1, 0, a);
    step(1, 0, 32'h7F800000, 1, 1, 0, a);
    step(0, 0, 0, 1, 1, 0, a);
    for (int i = 0; i < 300; i++)
      step(1, i[0], 32'h7F800001, 0, 0, 0, a);
    step(0, 0, 0, 1, 1, 0, a);
`endif

    // randomized traffic, input held while stalled
    v = 1'b0; s = 1'b0; d = '0; a = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (a || !v || rs) begin
        v = ($urandom_range(3) != 0);
        s = $urandom_range(1);
        d = $urandom();
        if ($urandom_range(7) == 0)
          d = {d[31], 8'hFF, d[22:0] | 23'h1};
      end
      r0 = ($urandom_range(3) != 0);
      r1 = ($urandom_range(1) != 0);
      rs = ($urandom_range(199) == 0);
      step(v, s, d, r0, r1, rs, a);
    end
    repeat (4) step(0, 0, 0, 1, 1, 0, a);

    en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
